// File: rtl/pipe_mem_arbiter_if.sv
// rtl/pipe_mem_arbiter_if.sv - fetch, data and memory ports of the unified-memory arbiter
// The slave modport is the arbiter's view; master is the surrounding pipeline and memory.
interface pipe_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [DATA_W/8-1:0]   dm_be;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [DATA_W-1:0]     dm_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and data
// Data wins by default; a starvation counter forces a fetch after STARVE_MAX blocking data grants.
module pipe_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_mem_arbiter_if.slave    bus
);
    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic { S_IDLE, S_WAIT } state_e;
    typedef enum logic { OWN_IF, OWN_DM } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_if, sel_dm;
    logic              if_gnt_c, dm_gnt_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        sel_if        = 1'b0;
        sel_dm        = 1'b0;
        if_gnt_c      = 1'b0;
        dm_gnt_c      = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.dm_rvalid = 1'b0;
        bus.dm_rdata  = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = 1'b0;

        // Every output, combinational ones included, is forced low while reset is high.
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    sel_if      = bus.if_req && (!bus.dm_req || cnt_q == CNT_MAX);
                    sel_dm      = !sel_if && bus.dm_req;
                    bus.mem_req = bus.if_req || bus.dm_req;
                    if (sel_if) begin
                        bus.mem_be   = '1;
                        bus.mem_addr = bus.if_addr;
                        if_gnt_c     = bus.mem_ready;
                    end else if (sel_dm) begin
                        bus.mem_we    = bus.dm_we;
                        bus.mem_be    = bus.dm_be;
                        bus.mem_addr  = bus.dm_addr;
                        bus.mem_wdata = bus.dm_wdata;
                        dm_gnt_c      = bus.mem_ready;
                    end
                    if (if_gnt_c) begin
                        state_d = S_WAIT;
                        owner_d = OWN_IF;
                    end else if (dm_gnt_c) begin
                        state_d = S_WAIT;
                        owner_d = OWN_DM;
                    end
                end
                S_WAIT: begin
                    bus.busy = 1'b1;
                    if (bus.mem_rvalid) begin
                        state_d = S_IDLE;
                        if (owner_q == OWN_DM) begin
                            bus.dm_rvalid = 1'b1;
                            bus.dm_rdata  = bus.mem_rdata;
                        end else begin
                            bus.if_rvalid = 1'b1;
                            bus.if_rdata  = bus.mem_rdata;
                        end
                    end
                end
            endcase

            // Only data grants that overtook a waiting fetch count towards starvation.
            if (!bus.if_req || if_gnt_c) begin
                cnt_d = '0;
            end else if (dm_gnt_c && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.if_gnt = if_gnt_c;
    assign bus.dm_gnt = dm_gnt_c;
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb/tb_pipe_mem_arbiter.sv - vector table, starvation sequence and randomized run for pipe_mem_arbiter
module tb_pipe_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    typedef struct packed {
        logic            rst;
        logic            if_req;
        logic [AW-1:0]   if_addr;
        logic            dm_req;
        logic            dm_we;
        logic [DW/8-1:0] dm_be;
        logic [AW-1:0]   dm_addr;
        logic [DW-1:0]   dm_wdata;
        logic            mem_ready;
        logic            mem_rvalid;
        logic [DW-1:0]   mem_rdata;
    } ins_t;

    typedef struct packed {
        logic            if_gnt;
        logic            if_rvalid;
        logic [DW-1:0]   if_rdata;
        logic            dm_gnt;
        logic            dm_rvalid;
        logic [DW-1:0]   dm_rdata;
        logic            mem_req;
        logic            mem_we;
        logic [DW/8-1:0] mem_be;
        logic [AW-1:0]   mem_addr;
        logic [DW-1:0]   mem_wdata;
        logic            busy;
    } outs_t;

    typedef struct {
        string name;
        ins_t  i;
        outs_t o;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    pipe_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    bit   m_busy;
    bit   m_owner_dm;
    int   m_streak;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic ins_t mi(logic r, logic ir, logic [31:0] ia, logic dr, logic we, logic [3:0] be,
                                logic [31:0] da, logic [31:0] wd, logic rdy, logic rv, logic [31:0] rd);
        ins_t v;
        v = '{rst: r, if_req: ir, if_addr: ia, dm_req: dr, dm_we: we, dm_be: be, dm_addr: da,
              dm_wdata: wd, mem_ready: rdy, mem_rvalid: rv, mem_rdata: rd};
        return v;
    endfunction

    function automatic outs_t mo(logic ig, logic irv, logic [31:0] ird, logic dg, logic drv, logic [31:0] drd,
                                 logic mr, logic mw, logic [3:0] mb, logic [31:0] ma, logic [31:0] mwd, logic bz);
        outs_t v;
        v = '{if_gnt: ig, if_rvalid: irv, if_rdata: ird, dm_gnt: dg, dm_rvalid: drv, dm_rdata: drd,
              mem_req: mr, mem_we: mw, mem_be: mb, mem_addr: ma, mem_wdata: mwd, busy: bz};
        return v;
    endfunction

    task automatic add(input string n, input ins_t i, input outs_t o);
        vec_t v;
        v.name = n;
        v.i    = i;
        v.o    = o;
        vecs.push_back(v);
    endtask

    task automatic drive(input ins_t i);
        reset          = i.rst;
        bus.if_req     = i.if_req;
        bus.if_addr    = i.if_addr;
        bus.dm_req     = i.dm_req;
        bus.dm_we      = i.dm_we;
        bus.dm_be      = i.dm_be;
        bus.dm_addr    = i.dm_addr;
        bus.dm_wdata   = i.dm_wdata;
        bus.mem_ready  = i.mem_ready;
        bus.mem_rvalid = i.mem_rvalid;
        bus.mem_rdata  = i.mem_rdata;
    endtask

    function automatic outs_t sample();
        return {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.dm_gnt, bus.dm_rvalid, bus.dm_rdata,
                bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.busy};
    endfunction

    // Transaction-level reference: one outstanding access, data preferred unless fetch has waited SM grants.
    function automatic outs_t model(input ins_t i);
        outs_t o;
        bit    take_if, take_dm;
        o = '0;
        if (i.rst) return o;
        if (m_busy) begin
            o.busy = 1'b1;
            if (i.mem_rvalid && m_owner_dm) begin
                o.dm_rvalid = 1'b1;
                o.dm_rdata  = i.mem_rdata;
            end else if (i.mem_rvalid) begin
                o.if_rvalid = 1'b1;
                o.if_rdata  = i.mem_rdata;
            end
            return o;
        end
        take_if   = i.if_req && (!i.dm_req || m_streak == SM);
        take_dm   = i.dm_req && !take_if;
        o.mem_req = i.if_req || i.dm_req;
        if (take_if) begin
            o.mem_be   = 4'hF;
            o.mem_addr = i.if_addr;
            o.if_gnt   = i.mem_ready;
        end
        if (take_dm) begin
            o.mem_we    = i.dm_we;
            o.mem_be    = i.dm_be;
            o.mem_addr  = i.dm_addr;
            o.mem_wdata = i.dm_wdata;
            o.dm_gnt    = i.mem_ready;
        end
        return o;
    endfunction

    task automatic model_step(input ins_t i, input outs_t e);
        if (i.rst) begin
            m_busy     = 1'b0;
            m_owner_dm = 1'b0;
            m_streak   = 0;
            return;
        end
        if (e.if_gnt || e.dm_gnt) begin
            m_busy     = 1'b1;
            m_owner_dm = e.dm_gnt;
        end else if (m_busy && i.mem_rvalid) begin
            m_busy = 1'b0;
        end
        if (!i.if_req || e.if_gnt) m_streak = 0;
        else if (e.dm_gnt && m_streak < SM) m_streak++;
    endtask

    initial begin
        ins_t  vi;
        outs_t ex;
        bit    prev_if, exp_if;
        bit    if_pend, dm_pend, rsp_pend;
        int    rsp_wait, n_if, n_dm;

        add("rst_all0", mi(1, 1, 'h10, 1, 1, 4'hF, 'h200, 'h1234, 1, 1, 'hFF), '0);
        add("rst_hold", mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), '0);
        add("f_gnt",    mi(0, 1, 'h10, 0, 0, 0, 0, 0, 1, 0, 0), mo(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 'h10, 0, 0));
        add("f_rsp",    mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h13), mo(0, 1, 'h13, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("f_gnt2",   mi(0, 1, 'h14, 0, 0, 0, 0, 0, 1, 0, 0), mo(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 'h14, 0, 0));
        add("f_rsp2",   mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h17), mo(0, 1, 'h17, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("s_dgnt",   mi(0, 1, 'h20, 1, 0, 4'hF, 'h100, 0, 1, 0, 0), mo(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 'h100, 0, 0));
        add("s_drsp",   mi(0, 1, 'h20, 0, 0, 0, 0, 0, 1, 1, 'hDEADBEEF),
                        mo(0, 0, 0, 0, 1, 'hDEADBEEF, 0, 0, 0, 0, 0, 1));
        add("s_igfn",   mi(0, 1, 'h20, 0, 0, 0, 0, 0, 1, 0, 0), mo(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 'h20, 0, 0));
        add("s_irsp",   mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'hCAFE), mo(0, 1, 'hCAFE, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("st_gnt",   mi(0, 0, 0, 1, 1, 4'h3, 'h200, 'h12345678, 1, 0, 0),
                        mo(0, 0, 0, 1, 0, 0, 1, 1, 4'h3, 'h200, 'h12345678, 0));
        add("st_wait",  mi(0, 0, 0, 1, 0, 4'hF, 'h400, 0, 1, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("st_ack",   mi(0, 0, 0, 1, 0, 4'hF, 'h400, 0, 1, 1, 'h55), mo(0, 0, 0, 0, 1, 'h55, 0, 0, 0, 0, 0, 1));
        add("st_next",  mi(0, 0, 0, 1, 0, 4'hF, 'h400, 0, 1, 0, 0), mo(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 'h400, 0, 0));
        add("st_rsp2",  mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h66), mo(0, 0, 0, 0, 1, 'h66, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++)
            add($sformatf("bp_hold%0d", k), mi(0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0, 0),
                mo(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 'h40, 0, 0));
        add("bp_gnt",   mi(0, 1, 'h40, 0, 0, 0, 0, 0, 1, 0, 0), mo(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 'h40, 0, 0));
        add("bp_rsp",   mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h41), mo(0, 1, 'h41, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("r_dgnt",   mi(0, 0, 0, 1, 0, 4'hF, 'h300, 0, 1, 0, 0), mo(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 'h300, 0, 0));
        add("r_rst",    mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), '0);
        add("r_rst_rv", mi(1, 1, 'h50, 1, 0, 4'hF, 'h300, 0, 1, 1, 'h77), '0);
        add("r_stray",  mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h99), '0);
        add("r_fgnt",   mi(0, 1, 'h50, 0, 0, 0, 0, 0, 1, 0, 0), mo(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 'h50, 0, 0));
        add("r_frsp",   mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h51), mo(0, 1, 'h51, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].i);
            #2;
            chk(vecs[k].name, sample(), vecs[k].o);
        end

        // Both requesters held; 1-cycle memory so grants land on even cycles, responses on odd ones.
        @(negedge clk);
        drive(mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        prev_if = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(mi(0, 1, 'h1000, 1, 0, 4'hF, 'h2000, 0, 1, (c % 2) == 1, c));
            #2;
            if (c % 2 == 0) begin
                exp_if = ((c / 2) % 5) == 4;
                chk($sformatf("starve_gnt%0d", c / 2), {bus.if_gnt, bus.dm_gnt}, exp_if ? 2'b10 : 2'b01);
                prev_if = exp_if;
            end else begin
                chk($sformatf("starve_rsp%0d", c / 2), {bus.if_rvalid, bus.dm_rvalid}, prev_if ? 2'b10 : 2'b01);
            end
        end

        vi = mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(vi);
        model_step(vi, '0);
        if_pend  = 0;
        dm_pend  = 0;
        rsp_pend = 0;
        rsp_wait = 0;
        n_if     = 0;
        n_dm     = 0;
        vi       = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            vi.rst = ($urandom_range(0, 199) == 0);
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend    = 1;
                vi.if_addr = $urandom;
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend     = 1;
                vi.dm_we    = $urandom_range(0, 1);
                vi.dm_be    = $urandom;
                vi.dm_addr  = $urandom;
                vi.dm_wdata = $urandom;
            end
            vi.if_req     = if_pend;
            vi.dm_req     = dm_pend;
            vi.mem_ready  = ($urandom_range(0, 3) != 0);
            vi.mem_rvalid = 1'b0;
            vi.mem_rdata  = '0;
            if (rsp_pend && rsp_wait == 0) begin
                vi.mem_rvalid = 1'b1;
                vi.mem_rdata  = $urandom;
            end else if (!rsp_pend && !m_busy && $urandom_range(0, 15) == 0) begin
                vi.mem_rvalid = 1'b1;
                vi.mem_rdata  = $urandom;
            end
            drive(vi);
            #2;
            ex = model(vi);
            chk($sformatf("rand%0d", c), sample(), ex);
            if (rsp_pend) begin
                if (rsp_wait == 0) rsp_pend = 0;
                else rsp_wait--;
            end
            if (vi.rst) rsp_pend = 0;
            if (ex.if_gnt) begin
                if_pend = 0;
                n_if++;
            end
            if (ex.dm_gnt) begin
                dm_pend = 0;
                n_dm++;
            end
            if (ex.if_gnt || ex.dm_gnt) begin
                rsp_pend = 1;
                rsp_wait = $urandom_range(0, 2);
            end
            model_step(vi, ex);
        end
        chk("rand_if_progress", n_if > 50, 1'b1);
        chk("rand_dm_progress", n_dm > 50, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) stage and the memory-access (MEM) stage.
- Allows at most one transaction in flight at a time.
- Grants data accesses over fetches by default. A starvation counter forces a fetch grant after STARVE_MAX consecutive data grants that blocked a pending fetch.
- A requester that has not been granted must stall its pipeline stage.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8
STARVE_MAX, 4, number of consecutive data grants taken while if_req is pending before fetch is forced; must be at least 1

Ports:
clk  in  1  clock; all logic is on the rising edge
reset  in  1  synchronous, active-high
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch response valid
if_rdata  out  DATA_W  fetch response data
dm_req  in  1  data request; held with its payload stable until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_be  in  DATA_W/8  byte enables, used for stores
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  data response valid; load data or store acknowledge
dm_rdata  out  DATA_W  load data
mem_req  out  1  request to memory
mem_we  out  1  write enable to memory
mem_be  out  DATA_W/8  byte enables to memory
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write data to memory
mem_ready  in  1  memory accepts a request when mem_req is also high
mem_rvalid  in  1  memory response or write acknowledge; exactly one per accepted request, at least 1 cycle after acceptance
mem_rdata  in  DATA_W  memory read data
busy  out  1  high while a transaction is outstanding

Behaviour:
- Registered state:
  - state: IDLE or WAIT.
  - owner: IF or DM.
  - starve_cnt: 0..STARVE_MAX.
- Reset:
  - Sets state=IDLE, owner=IF, starve_cnt=0.
  - While reset is high, every output is 0, including the combinational ones.
- Selection in IDLE, combinational:
  - Fetch is selected if if_req && (!dm_req || starve_cnt==STARVE_MAX).
  - Otherwise data is selected if dm_req.
  - Otherwise nothing is selected.
- Memory request in IDLE:
  - mem_req = if_req | dm_req.
  - mem_* payload is muxed from the selected requester.
  - For a fetch: mem_we=0, mem_be=all ones, mem_wdata=0.
  - When nothing is selected, the payload outputs are 0.
- Grant:
  - if_gnt = IDLE && fetch selected && mem_ready.
  - dm_gnt = IDLE && data selected && mem_ready.
  - At most one grant is asserted per cycle.
- Transition on grant: state goes to WAIT and owner is set to the granted requester.
- In WAIT:
  - mem_req=0, both gnt outputs are 0, busy=1.
- Response routing in WAIT:
  - On mem_rvalid, the response passes combinationally to the owner in the same cycle: owner_rvalid=1 and owner_rdata=mem_rdata.
  - Then state returns to IDLE.
  - Minimum issue spacing is therefore 2 cycles with a 1-cycle memory latency.
  - For a store, dm_rvalid is the write acknowledge and dm_rdata = mem_rdata (don't-care).
  - The non-owner's rvalid stays 0.
  - Each rdata output is 0 whenever its rvalid is 0.
- mem_rvalid while in IDLE is ignored; no output changes.
- starve_cnt updates on each clock edge, outside reset:
  - It is cleared whenever if_req==0 or if_gnt=1.
  - Otherwise it increments on dm_gnt while if_req=1, saturating at STARVE_MAX.
  - Otherwise it holds.
- Simultaneous if_req and dm_req with starve_cnt<STARVE_MAX: data wins and fetch waits.
- Request withdrawal before a grant is not permitted; if it happens, behaviour is defined by the combinational selection in that cycle only.
- Reset mid-transaction:
  - The transaction is abandoned and state returns to IDLE.
  - The memory shares the same reset, so no stale response follows.
- busy = (state==WAIT).

Test Plan:
1. Fetch only, 1-cycle memory:
   - Stimulus: if_req=1, addr 0x0000_0010, mem_ready=1; memory returns 0x0000_0013 one cycle after acceptance.
   - Required: if_gnt high in cycle 0; if_rvalid=1 with rdata 0x0000_0013 in cycle 1; next if_gnt no earlier than cycle 2.
2. Simultaneous requests:
   - Stimulus: if_req and dm_req both high; dm load from 0x100, memory returns 0xDEADBEEF.
   - Required: dm_gnt first; dm_rvalid=1 with 0xDEADBEEF; if_gnt in the following IDLE cycle; if_rvalid never overlaps dm_rvalid.
3. Store path:
   - Stimulus: dm_we=1, be=4'b0011, addr 0x200, wdata 0x1234_5678.
   - Required: mem_we=1, mem_be=0011, mem_wdata=0x12345678 on the granted cycle; dm_rvalid ack on the response cycle; if_rvalid=0 throughout.
4. Starvation, STARVE_MAX=4:
   - Stimulus: if_req and dm_req held high continuously.
   - Required: grant sequence DM, DM, DM, DM, IF, DM, and so on; starve_cnt reads 0,1,2,3,4,0.
5. Back-pressure:
   - Stimulus: mem_ready=0 for 3 cycles with if_req=1.
   - Required: mem_req=1 and if_gnt=0 for 3 cycles; mem_addr stable; if_gnt=1 on the first cycle with mem_ready=1.
6. Reset and stray response:
   - Stimulus: assert reset while in WAIT; after reset, pulse mem_rvalid while IDLE.
   - Required: all outputs 0 during reset; busy=0 afterwards; the stray mem_rvalid produces no if_rvalid or dm_rvalid.
